// File: rtl/reg_dump_uart.sv
// Debug scan-out: strobes the register file debug port over an index range and
// streams each captured 40-bit word as five 8N1 UART bytes, ending with a trailer.
module reg_dump_uart #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIRST_IDX    = 1,
   parameter int unsigned LAST_IDX     = 11,
   parameter logic [7:0]  TRAILER      = 8'h0A
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        ABORT,
   input  logic [39:0] R_IN,
   output logic [4:0]  INC_SEL,
   output logic        INC_STB,
   output logic        TX,
   output logic        BUSY,
   output logic        DONE
);

   localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [4:0]    IDX_FIRST = 5'(FIRST_IDX);
   localparam logic [4:0]    IDX_LAST  = 5'(LAST_IDX);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_STROBE = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_LOAD   = 3'd3;
   localparam logic [2:0] S_SEND   = 3'd4;
   localparam logic [2:0] S_NEXT   = 3'd5;
   localparam logic [2:0] S_TRAIL  = 3'd6;
   localparam logic [2:0] S_FINISH = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [4:0]    idx_q, idx_d;
   logic [39:0]   shadow_q, shadow_d;
   logic [CW-1:0] clk_q, clk_d;
   logic [3:0]    bit_q, bit_d;
   logic [2:0]    byte_q, byte_d;
   logic          abort_q, abort_d;
   logic          tx_q, tx_d;
   logic          stb_q, stb_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          abort_now;
   logic          bit_end;
   logic          stop_end;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         clk_q    <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         abort_q  <= 1'b0;
         tx_q     <= 1'b1;
         stb_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         clk_q    <= clk_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         abort_q  <= abort_d;
         tx_q     <= tx_d;
         stb_q    <= stb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      clk_d     = clk_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      abort_d   = abort_q;
      abort_now = abort_q | ABORT;
      bit_end   = (clk_q == CNT_LAST);
      stop_end  = bit_end && (bit_q == 4'd9);

      // Bit timing shared by data frames and the trailer frame
      if (state_q == S_SEND || state_q == S_TRAIL) begin
         if (bit_end) begin
            clk_d = '0;
            if (bit_q == 4'd9) begin
               bit_d    = '0;
               byte_d   = byte_q + 3'd1;
               shadow_d = {8'h00, shadow_q[39:8]};
            end else begin
               bit_d = bit_q + 4'd1;
            end
         end else begin
            clk_d = clk_q + CW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            if (START) begin
               idx_d   = IDX_FIRST;
               state_d = S_STROBE;
            end
         end
         S_STROBE: state_d = abort_now ? S_IDLE : S_WAIT;
         S_WAIT:   state_d = abort_now ? S_IDLE : S_LOAD;
         S_LOAD: begin
            if (abort_now) begin
               state_d = S_IDLE;
            end else begin
               shadow_d = {R_IN[15:8], R_IN[23:16], R_IN[31:24], R_IN[39:32], R_IN[7:0]};
               clk_d    = '0;
               bit_d    = '0;
               byte_d   = '0;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            abort_d = abort_now;
            // Final stop-bit cycle of the last byte is spent in NEXT
            if (stop_end && abort_now) begin
               state_d = S_IDLE;
            end else if (byte_q == 3'd4 && bit_q == 4'd9 && clk_q == CNT_PRE) begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (abort_now) begin
               state_d = S_IDLE;
            end else if (idx_q == IDX_LAST) begin
               shadow_d = {32'h0, TRAILER};
               clk_d    = '0;
               bit_d    = '0;
               state_d  = S_TRAIL;
            end else begin
               idx_d   = idx_q + 5'd1;
               state_d = S_STROBE;
            end
         end
         S_TRAIL: begin
            abort_d = abort_now;
            if (stop_end) begin
               state_d = abort_now ? S_IDLE : S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      stb_d  = (state_d == S_STROBE);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FINISH);
      tx_d   = 1'b1;
      if (state_d == S_SEND || state_d == S_TRAIL) begin
         if (bit_d == 4'd0) begin
            tx_d = 1'b0;
         end else if (bit_d <= 4'd8) begin
            tx_d = shadow_d[3'(bit_d - 4'd1)];
         end
      end
   end

   assign INC_SEL = idx_q;
   assign INC_STB = stb_q;
   assign TX      = tx_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;

endmodule
